// File: rtl/prio_scan_if.sv
// Handshake bundle for the priority scanner: a vector input channel,
// a flush control and an index beat output channel.
interface prio_scan_if #(
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    out_idx;
    logic             out_last;
    logic             out_none;

    modport master (
        output in_valid, in_vec, flush, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );

    modport slave (
        input  in_valid, in_vec, flush, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/prio_scan.sv
// Priority scanner: takes a request vector and emits one index beat
// per set bit in priority order (single beat with out_none for zero).
module prio_scan #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    prio_scan_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] pick_mask;
    logic             found;
    logic             scanning;
    logic             is_last;
    logic             is_none;
    logic             fire;
    logic             accept;

    // Rank order walk: step i visits the bit whose rank is i.
    always_comb begin
        pick_idx  = '0;
        pick_mask = '0;
        found     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (!found && rem_q[WIDTH-1-i]) begin
                    found                = 1'b1;
                    pick_idx             = IW'(i);
                    pick_mask[WIDTH-1-i] = 1'b1;
                end
            end else begin
                if (!found && rem_q[i]) begin
                    found        = 1'b1;
                    pick_idx     = IW'(i);
                    pick_mask[i] = 1'b1;
                end
            end
        end
    end

    assign scanning = (state_q == SCAN);
    assign is_none  = (rem_q == '0);
    assign is_last  = ((rem_q & (rem_q - ONE)) == '0);
    assign fire     = scanning && bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !bus.flush && (!scanning || (fire && is_last));
    assign bus.out_valid = scanning;
    assign bus.out_idx   = scanning ? pick_idx : '0;
    assign bus.out_last  = scanning && is_last;
    assign bus.out_none  = scanning && is_none;

    // Next state: flush wins, then a new load, then beat consumption.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (bus.flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (accept) begin
            state_d = SCAN;
            rem_d   = bus.in_vec;
        end else if (fire && !is_last) begin
            rem_d = rem_q & ~pick_mask;
        end else if (fire) begin
            state_d = IDLE;
            rem_d   = '0;
        end
    end

    // State and remaining-vector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_prio_scan.sv
// Directed bench for prio_scan: a 32-bit MSB-first and an 8-bit
// LSB-first instance, checked by per-instance scoreboard monitors.
module tb_prio_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prio_scan_if #(.WIDTH(32)) b32 ();
    prio_scan_if #(.WIDTH(8))  b8 ();

    prio_scan #(.WIDTH(32), .MSB_FIRST(1'b1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    prio_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    beat_t q32[$];
    beat_t q8[$];
    int    checks = 0;
    int    errors = 0;

    function automatic beat_t mk(input int idx, input bit last, input bit none);
        beat_t b;
        b.idx  = 5'(idx);
        b.last = last;
        b.none = none;
        return b;
    endfunction

    function void chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        beat_t e;
        if (!rst && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat32_unexpected: got idx %0d expected no beat",
                         b32.out_idx);
            end else begin
                e = q32.pop_front();
                chk("beat32_idx", 32'(b32.out_idx), 32'(e.idx));
                chk("beat32_last", 32'(b32.out_last), 32'(e.last));
                chk("beat32_none", 32'(b32.out_none), 32'(e.none));
            end
        end
    end

    // Scoreboard monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        beat_t e;
        if (!rst && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat8_unexpected: got idx %0d expected no beat",
                         b8.out_idx);
            end else begin
                e = q8.pop_front();
                chk("beat8_idx", 32'(b8.out_idx), 32'(e.idx));
                chk("beat8_last", 32'(b8.out_last), 32'(e.last));
                chk("beat8_none", 32'(b8.out_none), 32'(e.none));
            end
        end
    end

    // Entered and left at posedge+1; holds in_valid until accepted.
    task automatic send32(input logic [31:0] v);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        b32.in_vec   = v;
        b32.in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = b32.in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        b32.in_valid = 1'b0;
        b32.in_vec   = '0;
        chk("send32_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain32(input string name);
        int n;
        n = 0;
        while (q32.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, 32'(q32.size()), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_idle"}, 32'(b32.out_valid), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        b32.in_valid = 1'b0; b32.in_vec = '0;
        b32.flush = 1'b0;    b32.out_ready = 1'b1;
        b8.in_valid = 1'b0;  b8.in_vec = '0;
        b8.flush = 1'b0;     b8.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid32", 32'(b32.out_valid), 32'd0);
        chk("rst_idx32", 32'(b32.out_idx), 32'd0);
        chk("rst_last32", 32'(b32.out_last), 32'd0);
        chk("rst_none32", 32'(b32.out_none), 32'd0);
        chk("rst_ready32", 32'(b32.in_ready), 32'd1);
        chk("rst_valid8", 32'(b8.out_valid), 32'd0);
        chk("rst_ready8", 32'(b8.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two set bits at the extremes.
        q32.push_back(mk(0, 1'b0, 1'b0));
        q32.push_back(mk(31, 1'b1, 1'b0));
        send32(32'h8000_0001);
        drain32("two_bit");

        // All-zero vector gives a single none beat.
        q32.push_back(mk(0, 1'b1, 1'b1));
        send32(32'h0000_0000);
        drain32("empty");

        // Stall on the first beat for three cycles.
        b32.out_ready = 1'b0;
        q32.push_back(mk(4, 1'b0, 1'b0));
        q32.push_back(mk(5, 1'b0, 1'b0));
        q32.push_back(mk(6, 1'b0, 1'b0));
        q32.push_back(mk(7, 1'b1, 1'b0));
        send32(32'h0F00_0000);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(b32.out_valid), 32'd1);
            chk("stall_idx", 32'(b32.out_idx), 32'd4);
            chk("stall_last", 32'(b32.out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
        drain32("stall");

        // Back-to-back: second vector lands during the last beat.
        q32.push_back(mk(0, 1'b0, 1'b0));
        q32.push_back(mk(1, 1'b1, 1'b0));
        q32.push_back(mk(31, 1'b1, 1'b0));
        send32(32'hC000_0000);
        send32(32'h0000_0001);
        @(negedge clk);
        chk("b2b_valid", 32'(b32.out_valid), 32'd1);
        chk("b2b_idx", 32'(b32.out_idx), 32'd31);
        #1;
        drain32("b2b");

        // LSB-first 8-bit instance.
        q8.push_back(mk(1, 1'b0, 1'b0));
        q8.push_back(mk(2, 1'b1, 1'b0));
        b8.in_vec   = 8'b0000_0110;
        b8.in_valid = 1'b1;
        @(negedge clk);
        chk("lsb_accept", 32'(b8.in_ready), 32'd1);
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.in_vec   = '0;
        n = 0;
        while (q8.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("lsb_drained", 32'(q8.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("lsb_idle", 32'(b8.out_valid), 32'd0);

        // Flush after the first beat; a vector offered meanwhile is refused.
        q32.push_back(mk(0, 1'b0, 1'b0));
        send32(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        b32.flush     = 1'b1;
        b32.in_valid  = 1'b1;
        b32.in_vec    = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("flush_in_ready", 32'(b32.in_ready), 32'd0);
        @(posedge clk);
        #1;
        b32.flush     = 1'b0;
        b32.in_valid  = 1'b0;
        b32.in_vec    = '0;
        b32.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_drop", 32'(b32.out_valid), 32'd0);
        @(posedge clk);
        #1;
        q32.push_back(mk(30, 1'b1, 1'b0));
        send32(32'h0000_0002);
        drain32("after_flush");

        // Reset mid-scan drops out_valid at once.
        q32.push_back(mk(0, 1'b0, 1'b0));
        send32(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(b32.out_valid), 32'd0);
        chk("rst_mid_idx", 32'(b32.out_idx), 32'd0);
        chk("rst_mid_ready", 32'(b32.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b32.out_ready = 1'b1;
        q32.push_back(mk(30, 1'b1, 1'b0));
        send32(32'h0000_0002);
        drain32("after_rst");

        repeat (3) @(posedge clk);
        chk("final_q32", 32'(q32.size()), 32'd0);
        chk("final_q8", 32'(q8.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prio_scan.md
PRIO_SCAN -- requirements
Module: prio_scan

Interface
REQ-001 Parameter WIDTH, default 32: request vector width; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = scan from bit WIDTH-1 down to bit 0; 0 = scan from bit 0 up to bit WIDTH-1.
REQ-003 Localparam IW = $clog2(WIDTH): index width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  request vector offered.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_vec  input  WIDTH  request vector; sampled when in_valid && in_ready.
REQ-009 flush  input  1  synchronous abort of the current scan.
REQ-010 out_valid  output  1  an index beat is presented.
REQ-011 out_ready  input  1  consumer accepts the beat.
REQ-012 out_idx  output  IW  rank of the highest-priority remaining set bit.
REQ-013 out_last  output  1  the current beat is the final beat for this vector.
REQ-014 out_none  output  1  the accepted vector was all-zero.

Function
REQ-015 The block SHALL have two states: IDLE and SCAN, plus a WIDTH-bit remaining-vector register rem.
- IDLE: out_valid = 0.
- SCAN: out_valid = 1.
REQ-016 On in_valid && in_ready, rem <= in_vec and state <= SCAN; the first beat SHALL be valid on the following cycle (latency 1).
REQ-017 Rank rule:
- MSB_FIRST=1: set bit k reports out_idx = WIDTH-1-k; bit WIDTH-1 is highest priority.
- MSB_FIRST=0: set bit k reports out_idx = k; bit 0 is highest priority.
REQ-018 In SCAN, out_idx SHALL be the rank of the highest-priority set bit of rem; it SHALL be 0 when rem == 0 or out_valid == 0.
REQ-019 out_last SHALL be 1 in SCAN when rem has at most one set bit; it SHALL be 0 otherwise.
REQ-020 out_none SHALL be 1 in SCAN only when rem == 0; it SHALL be 0 otherwise. An all-zero input therefore SHALL yield exactly one beat: out_none=1, out_last=1, out_idx=0.
REQ-021 Beat transfer:
- On out_valid && out_ready && !out_last: clear the reported bit in rem; stay in SCAN.
- On out_valid && out_ready && out_last: go to IDLE, unless a new vector is accepted in the same cycle (REQ-022).
REQ-022 in_ready = !flush && (state == IDLE || (out_valid && out_ready && out_last)).
- Back-to-back: a vector accepted in the same cycle as the last beat SHALL be loaded with no bubble cycle.
REQ-023 While out_valid && !out_ready, out_idx, out_last and out_none SHALL be held stable and rem SHALL not change.
REQ-024 Beats SHALL be emitted in strict priority order, one per accepted transfer. The number of beats per vector SHALL equal popcount(in_vec), or 1 if in_vec == 0.
REQ-025 flush = 1 SHALL force state <= IDLE and rem <= 0 at the next edge.
- A beat transferred in that cycle still counts as consumed.
- No input SHALL be accepted in that cycle.
REQ-026 in_vec SHALL be ignored whenever in_ready = 0.

Reset
REQ-027 While rst is high: state = IDLE, rem = 0, out_valid = 0, out_idx = 0, out_last = 0, out_none = 0, in_ready = 1 (when flush = 0).
REQ-028 Reset asserted mid-scan SHALL immediately drop out_valid. The partially scanned vector SHALL be discarded; no beat from it SHALL appear after reset release.

Verification
REQ-029 Two-bit vector: WIDTH=32, MSB_FIRST=1, in_vec=32'h8000_0001, out_ready=1 -> beat idx=0 last=0, then beat idx=31 last=1, then IDLE.
REQ-030 Empty vector: in_vec=0 -> exactly one beat with idx=0, none=1, last=1.
REQ-031 Stall: in_vec=32'h0F00_0000, out_ready low 3 cycles at the first beat -> idx=4 held stable throughout the stall; then beats idx=4,5,6,7 with last on idx=7.
REQ-032 Back-to-back: the second vector 32'h0000_0001 is offered during the last beat of the first vector -> accepted that cycle; the next cycle presents idx=31 with no bubble.
REQ-033 LSB-first: WIDTH=8, MSB_FIRST=0, in_vec=8'b0000_0110 -> beats idx=1, then idx=2 (last).
REQ-034 Abort cases:
- flush after the first beat of 32'hFFFF_FFFF -> out_valid=0 next cycle.
- The same case with rst instead of flush -> out_valid=0 immediately.
- In both cases, the next vector 32'h0000_0002 yields the single beat idx=30.
